rv32_csr_trap_unit: RTL and testbench

//  Parametrised machine-mode CSR file and trap controller for the rv32i core.

---
 rtl/rv32_csr_trap_unit.sv | 266 ++++++++++++++++++++++++++
 tb/tb_rv32_csr_trap_unit.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_csr_trap_unit.sv
// Machine-mode CSR file, counters and trap controller for the rv32i core.
// Ports: clk/rst_n, Zicsr access (csr_*), retire/timer_tick counters,
// exc_*/irq_*/mret trap events, msip/mtip/meip/lirq levels,
// irq_pending, trap_redirect/trap_pc redirect pulse.
module rv32_csr_trap_unit #(
    parameter int          HART_ID     = 0,
    parameter int          COUNTER_W   = 64,
    parameter int          NUM_LIRQ    = 4,
    parameter logic [31:0] RESET_MTVEC = 32'h0,
    parameter bit          VECTORED_EN = 1'b1,
    localparam int         LIRQ_W      = (NUM_LIRQ > 0) ? NUM_LIRQ : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              csr_req,
    input  logic [1:0]        csr_op,
    input  logic [11:0]       csr_addr,
    input  logic [31:0]       csr_wdata,
    input  logic              csr_wr_en,
    output logic              csr_ack,
    output logic [31:0]       csr_rdata,
    output logic              csr_illegal,
    input  logic              retire,
    input  logic              timer_tick,
    input  logic              exc_valid,
    input  logic [4:0]        exc_cause,
    input  logic [31:0]       exc_pc,
    input  logic [31:0]       exc_tval,
    input  logic              mret,
    input  logic              msip,
    input  logic              mtip,
    input  logic              meip,
    input  logic [LIRQ_W-1:0] lirq,
    output logic              irq_pending,
    input  logic              irq_take,
    input  logic [31:0]       irq_pc,
    output logic              trap_redirect,
    output logic [31:0]       trap_pc
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_TIME      = 12'hC01;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_TIMEH     = 12'hC81;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;

    localparam logic [31:0] MISA_VAL   = 32'h4000_0100;
    localparam logic [31:0] LIRQ_MASK  =
        32'((64'd1 << NUM_LIRQ) - 64'd1) << 16;
    localparam logic [31:0] MIE_MASK   = LIRQ_MASK | 32'h0000_0888;
    localparam logic [31:0] MTVEC_MASK =
        VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

    logic                 st_mie;
    logic                 st_mpie;
    logic [31:0]          mie_q;
    logic [31:0]          mtvec_q;
    logic [31:0]          mscratch_q;
    logic [31:0]          mepc_q;
    logic [31:0]          mcause_q;
    logic [31:0]          mtval_q;
    logic [COUNTER_W-1:0] cycle_q;
    logic [COUNTER_W-1:0] time_q;
    logic [COUNTER_W-1:0] instret_q;
    logic [COUNTER_W-1:0] cycle_n;
    logic [COUNTER_W-1:0] time_n;
    logic [COUNTER_W-1:0] instret_n;

    // Zero-extended views so the high halves read 0 when COUNTER_W < 64
    logic [63:0] cycle_x;
    logic [63:0] time_x;
    logic [63:0] instret_x;

    assign cycle_x   = 64'(cycle_q);
    assign time_x    = 64'(time_q);
    assign instret_x = 64'(instret_q);

    logic [31:0] mip;
    logic [31:0] pend;
    logic [4:0]  irq_code;
    logic [31:0] irq_target;
    logic        irq_go;

    always_comb begin
        mip     = 32'h0;
        mip[3]  = msip;
        mip[7]  = mtip;
        mip[11] = meip;
        for (int i = 0; i < NUM_LIRQ; i++) begin
            mip[16+i] = lirq[i];
        end
    end

    assign pend        = mip & mie_q;
    assign irq_pending = st_mie & (|pend);
    assign irq_go      = irq_take & irq_pending;

    // Later assignments override: 11 > 3 > 7 > lowest local index
    always_comb begin
        irq_code = 5'd0;
        for (int i = NUM_LIRQ - 1; i >= 0; i--) begin
            if (pend[16+i]) irq_code = 5'(16 + i);
        end
        if (pend[7])  irq_code = 5'd7;
        if (pend[3])  irq_code = 5'd3;
        if (pend[11]) irq_code = 5'd11;
    end

    assign irq_target = {mtvec_q[31:2], 2'b00} +
        (mtvec_q[0] ? {25'h0, irq_code, 2'b00} : 32'h0);

    logic [31:0] rd_val;
    logic        known;
    logic        legal;
    logic [31:0] new_val;
    logic        csr_go;
    logic        wr_go;

    always_comb begin
        rd_val = 32'h0;
        known  = 1'b1;
        case (csr_addr)
            A_MSTATUS:   rd_val = {19'h0, 2'b11, 3'h0, st_mpie,
                                   3'h0, st_mie, 3'h0};
            A_MISA:      rd_val = MISA_VAL;
            A_MIE:       rd_val = mie_q;
            A_MTVEC:     rd_val = mtvec_q;
            A_MSCRATCH:  rd_val = mscratch_q;
            A_MEPC:      rd_val = mepc_q;
            A_MCAUSE:    rd_val = mcause_q;
            A_MTVAL:     rd_val = mtval_q;
            A_MIP:       rd_val = mip;
            A_MVENDORID: rd_val = 32'h0;
            A_MARCHID:   rd_val = 32'h0;
            A_MIMPID:    rd_val = 32'h0;
            A_MHARTID:   rd_val = 32'(HART_ID);
            A_MCYCLE:    rd_val = cycle_x[31:0];
            A_MCYCLEH:   rd_val = cycle_x[63:32];
            A_MINSTRET:  rd_val = instret_x[31:0];
            A_MINSTRETH: rd_val = instret_x[63:32];
            A_CYCLE:     rd_val = cycle_x[31:0];
            A_CYCLEH:    rd_val = cycle_x[63:32];
            A_TIME:      rd_val = time_x[31:0];
            A_TIMEH:     rd_val = time_x[63:32];
            A_INSTRET:   rd_val = instret_x[31:0];
            A_INSTRETH:  rd_val = instret_x[63:32];
            default:     known  = 1'b0;
        endcase
    end

    assign legal = known & ~(csr_wr_en & (csr_addr[11:10] == 2'b11));

    always_comb begin
        case (csr_op)
            2'b01:   new_val = csr_wdata;
            2'b10:   new_val = rd_val | csr_wdata;
            2'b11:   new_val = rd_val & ~csr_wdata;
            default: new_val = rd_val;
        endcase
    end

    assign csr_go = csr_req & ~exc_valid & ~irq_go & ~mret;
    assign wr_go  = csr_go & legal & csr_wr_en;

    // A write to one half replaces that cycle's increment; other half holds
    always_comb begin
        cycle_n   = cycle_q + COUNTER_W'(1);
        time_n    = time_q + COUNTER_W'(timer_tick);
        instret_n = instret_q + COUNTER_W'(retire);
        if (wr_go && csr_addr == A_MCYCLE)
            cycle_n = COUNTER_W'({cycle_x[63:32], new_val});
        if (wr_go && csr_addr == A_MCYCLEH)
            cycle_n = COUNTER_W'({new_val, cycle_x[31:0]});
        if (wr_go && csr_addr == A_MINSTRET)
            instret_n = COUNTER_W'({instret_x[63:32], new_val});
        if (wr_go && csr_addr == A_MINSTRETH)
            instret_n = COUNTER_W'({new_val, instret_x[31:0]});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_mie        <= 1'b0;
            st_mpie       <= 1'b0;
            mie_q         <= 32'h0;
            mtvec_q       <= RESET_MTVEC & MTVEC_MASK;
            mscratch_q    <= 32'h0;
            mepc_q        <= 32'h0;
            mcause_q      <= 32'h0;
            mtval_q       <= 32'h0;
            cycle_q       <= '0;
            time_q        <= '0;
            instret_q     <= '0;
            csr_ack       <= 1'b0;
            csr_rdata     <= 32'h0;
            csr_illegal   <= 1'b0;
            trap_redirect <= 1'b0;
            trap_pc       <= 32'h0;
        end else begin
            csr_ack       <= 1'b0;
            trap_redirect <= 1'b0;
            cycle_q       <= cycle_n;
            time_q        <= time_n;
            instret_q     <= instret_n;
            if (exc_valid) begin
                mepc_q        <= exc_pc & ~32'h3;
                mcause_q      <= {27'h0, exc_cause};
                mtval_q       <= exc_tval;
                st_mpie       <= st_mie;
                st_mie        <= 1'b0;
                trap_redirect <= 1'b1;
                trap_pc       <= mtvec_q & ~32'h3;
            end else if (irq_go) begin
                mepc_q        <= irq_pc & ~32'h3;
                mcause_q      <= {1'b1, 26'h0, irq_code};
                mtval_q       <= 32'h0;
                st_mpie       <= st_mie;
                st_mie        <= 1'b0;
                trap_redirect <= 1'b1;
                trap_pc       <= irq_target;
            end else if (mret) begin
                st_mie        <= st_mpie;
                st_mpie       <= 1'b1;
                trap_redirect <= 1'b1;
                trap_pc       <= mepc_q;
            end else if (csr_req) begin
                csr_ack     <= 1'b1;
                csr_illegal <= ~legal;
                csr_rdata   <= legal ? rd_val : 32'h0;
                if (wr_go) begin
                    case (csr_addr)
                        A_MSTATUS: begin
                            st_mie  <= new_val[3];
                            st_mpie <= new_val[7];
                        end
                        A_MIE:      mie_q      <= new_val & MIE_MASK;
                        A_MTVEC:    mtvec_q    <= new_val & MTVEC_MASK;
                        A_MSCRATCH: mscratch_q <= new_val;
                        A_MEPC:     mepc_q     <= new_val & ~32'h3;
                        A_MCAUSE:   mcause_q   <= new_val;
                        A_MTVAL:    mtval_q    <= new_val;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32_csr_trap_unit.sv
// Directed self-checking bench for rv32_csr_trap_unit.
// u0: 64-bit counters, vectored; u1: 32-bit counters, direct-only, 2 lirq.
module tb_rv32_csr_trap_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_req;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_wr_en;
    logic        retire;
    logic        timer_tick;
    logic        exc_valid;
    logic [4:0]  exc_cause;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        mret;
    logic        msip;
    logic        mtip;
    logic        meip;
    logic [3:0]  lirq;
    logic        irq_take;
    logic [31:0] irq_pc;

    logic        csr_ack;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        irq_pending;
    logic        trap_redirect;
    logic [31:0] trap_pc;

    logic        csr_ack1;
    logic [31:0] csr_rdata1;
    logic        csr_illegal1;
    logic        irq_pending1;
    logic        trap_redirect1;
    logic [31:0] trap_pc1;

    int tests_run = 0;
    int fails = 0;

    logic        ack_s;
    logic [31:0] rd_s;
    logic        ill_s;
    logic [31:0] rd1_s;

    always #5 clk = ~clk;

    rv32_csr_trap_unit #(
        .HART_ID(5), .COUNTER_W(64), .NUM_LIRQ(4),
        .RESET_MTVEC(32'h100), .VECTORED_EN(1'b1)
    ) u0 (
        .clk(clk), .rst_n(rst_n),
        .csr_req(csr_req), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_wr_en(csr_wr_en),
        .csr_ack(csr_ack), .csr_rdata(csr_rdata),
        .csr_illegal(csr_illegal),
        .retire(retire), .timer_tick(timer_tick),
        .exc_valid(exc_valid), .exc_cause(exc_cause),
        .exc_pc(exc_pc), .exc_tval(exc_tval), .mret(mret),
        .msip(msip), .mtip(mtip), .meip(meip), .lirq(lirq),
        .irq_pending(irq_pending), .irq_take(irq_take),
        .irq_pc(irq_pc), .trap_redirect(trap_redirect),
        .trap_pc(trap_pc)
    );

    rv32_csr_trap_unit #(
        .HART_ID(0), .COUNTER_W(32), .NUM_LIRQ(2),
        .RESET_MTVEC(32'h0), .VECTORED_EN(1'b0)
    ) u1 (
        .clk(clk), .rst_n(rst_n),
        .csr_req(csr_req), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_wr_en(csr_wr_en),
        .csr_ack(csr_ack1), .csr_rdata(csr_rdata1),
        .csr_illegal(csr_illegal1),
        .retire(retire), .timer_tick(timer_tick),
        .exc_valid(exc_valid), .exc_cause(exc_cause),
        .exc_pc(exc_pc), .exc_tval(exc_tval), .mret(mret),
        .msip(msip), .mtip(mtip), .meip(meip), .lirq(lirq[1:0]),
        .irq_pending(irq_pending1), .irq_take(irq_take),
        .irq_pc(irq_pc), .trap_redirect(trap_redirect1),
        .trap_pc(trap_pc1)
    );

    // One access: drive at negedge, commit on posedge, sample next negedge
    task automatic csr_do(input logic [1:0] op, input logic [11:0] addr,
                          input logic [31:0] wd, input logic we);
        csr_req   = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wd;
        csr_wr_en = we;
        @(posedge clk); #1;
        csr_req   = 1'b0;
        csr_wr_en = 1'b0;
        @(negedge clk);
        ack_s = csr_ack;
        rd_s  = csr_rdata;
        ill_s = csr_illegal;
        rd1_s = csr_rdata1;
    endtask

    task automatic rd(input logic [11:0] addr);
        csr_do(2'b10, addr, 32'h0, 1'b0);
    endtask

    task automatic pulse_exc(input logic [4:0] c, input logic [31:0] pc,
                             input logic [31:0] tv);
        exc_valid = 1'b1; exc_cause = c; exc_pc = pc; exc_tval = tv;
        @(posedge clk); #1;
        exc_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_take(input logic [31:0] pc);
        irq_take = 1'b1; irq_pc = pc;
        @(posedge clk); #1;
        irq_take = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_mret;
        mret = 1'b1;
        @(posedge clk); #1;
        mret = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({csr_ack, csr_rdata, csr_illegal, irq_pending,
             trap_redirect, trap_pc} !== 67'h0) begin
            fails++;
            $display("FAIL reset_outputs: got ack=%b rd=%h ill=%b pend=%b redir=%b pc=%h want all 0",
                     csr_ack, csr_rdata, csr_illegal, irq_pending,
                     trap_redirect, trap_pc);
        end
        rst_n = 1'b1;
        rd(12'h300);
        tests_run++;
        if (rd_s !== 32'h1800) begin
            fails++; $display("FAIL reset_mstatus: got %h want 00001800", rd_s);
        end
        rd(12'h305);
        tests_run++;
        if (rd_s !== 32'h100) begin
            fails++; $display("FAIL reset_mtvec: got %h want 00000100", rd_s);
        end
        rd(12'h301);
        tests_run++;
        if (rd_s !== 32'h4000_0100) begin
            fails++; $display("FAIL misa: got %h want 40000100", rd_s);
        end
        rd(12'hF14);
        tests_run++;
        if (rd_s !== 32'h5 || rd1_s !== 32'h0) begin
            fails++; $display("FAIL mhartid: got %h/%h want 5/0", rd_s, rd1_s);
        end
        rd(12'hB02);
        tests_run++;
        if (rd_s !== 32'h0) begin
            fails++; $display("FAIL reset_minstret: got %h want 0", rd_s);
        end
    endtask

    task automatic test_rw_rs;
        csr_do(2'b01, 12'h340, 32'hA5A5_0000, 1'b1);
        tests_run++;
        if (ack_s !== 1'b1 || rd_s !== 32'h0 || ill_s !== 1'b0) begin
            fails++; $display("FAIL rw_mscratch: got ack=%b rd=%h ill=%b want 1/0/0", ack_s, rd_s, ill_s);
        end
        csr_do(2'b10, 12'h340, 32'h0000_00FF, 1'b1);
        tests_run++;
        if (ack_s !== 1'b1 || rd_s !== 32'hA5A5_0000) begin
            fails++; $display("FAIL rs_mscratch: got ack=%b rd=%h want 1/a5a50000", ack_s, rd_s);
        end
        tests_run++;
        if (csr_ack !== 1'b1) begin
            fails++; $display("FAIL ack_pulse_high: got %b want 1", csr_ack);
        end
        @(negedge clk);
        tests_run++;
        if (csr_ack !== 1'b0) begin
            fails++; $display("FAIL ack_pulse_low: got %b want 0", csr_ack);
        end
        csr_do(2'b11, 12'h340, 32'h0000_000F, 1'b1);
        tests_run++;
        if (rd_s !== 32'hA5A5_00FF) begin
            fails++; $display("FAIL rc_mscratch_old: got %h want a5a500ff", rd_s);
        end
        rd(12'h340);
        tests_run++;
        if (rd_s !== 32'hA5A5_00F0) begin
            fails++; $display("FAIL rc_mscratch_new: got %h want a5a500f0", rd_s);
        end
    endtask

    task automatic test_back_to_back;
        csr_req = 1'b1; csr_op = 2'b01; csr_addr = 12'h340;
        csr_wdata = 32'h11; csr_wr_en = 1'b1;
        @(negedge clk);
        tests_run++;
        if (csr_ack !== 1'b1 || csr_rdata !== 32'hA5A5_00F0) begin
            fails++; $display("FAIL b2b_first: got ack=%b rd=%h want 1/a5a500f0", csr_ack, csr_rdata);
        end
        csr_op = 2'b10; csr_wdata = 32'h22;
        @(posedge clk); #1;
        csr_req = 1'b0; csr_wr_en = 1'b0;
        @(negedge clk);
        tests_run++;
        if (csr_ack !== 1'b1 || csr_rdata !== 32'h11) begin
            fails++; $display("FAIL b2b_second: got ack=%b rd=%h want 1/11", csr_ack, csr_rdata);
        end
        rd(12'h340);
        tests_run++;
        if (rd_s !== 32'h33) begin
            fails++; $display("FAIL b2b_final: got %h want 33", rd_s);
        end
    endtask

    task automatic test_counters;
        retire = 1'b1;
        csr_do(2'b01, 12'hB02, 32'hFFFF_FFFF, 1'b1);
        retire = 1'b0;
        rd(12'hB02);
        tests_run++;
        if (rd_s !== 32'hFFFF_FFFF || rd1_s !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL minstret_write_wins: got %h/%h want ffffffff", rd_s, rd1_s);
        end
        retire = 1'b1;
        @(posedge clk); #1;
        retire = 1'b0;
        @(negedge clk);
        rd(12'hB02);
        tests_run++;
        if (rd_s !== 32'h0 || rd1_s !== 32'h0) begin
            fails++; $display("FAIL minstret_wrap: got %h/%h want 0/0", rd_s, rd1_s);
        end
        rd(12'hB82);
        tests_run++;
        if (rd_s !== 32'h1 || rd1_s !== 32'h0) begin
            fails++; $display("FAIL minstreth_carry: got %h/%h want 1/0", rd_s, rd1_s);
        end
        csr_do(2'b01, 12'hB82, 32'h7, 1'b1);
        rd(12'hB82);
        tests_run++;
        if (rd_s !== 32'h7 || rd1_s !== 32'h0) begin
            fails++; $display("FAIL minstreth_write: got %h/%h want 7/0", rd_s, rd1_s);
        end
        timer_tick = 1'b1;
        repeat (3) @(posedge clk);
        #1 timer_tick = 1'b0;
        @(negedge clk);
        rd(12'hC01);
        tests_run++;
        if (rd_s !== 32'h3 || rd1_s !== 32'h3) begin
            fails++; $display("FAIL time_count: got %h/%h want 3/3", rd_s, rd1_s);
        end
    endtask

    task automatic test_exception;
        csr_do(2'b01, 12'h300, 32'h8, 1'b1);
        csr_do(2'b01, 12'h305, 32'h200, 1'b1);
        pulse_exc(5'd2, 32'h104, 32'h13);
        tests_run++;
        if (trap_redirect !== 1'b1 || trap_pc !== 32'h200) begin
            fails++; $display("FAIL exc_redirect: got %b/%h want 1/200", trap_redirect, trap_pc);
        end
        @(negedge clk);
        tests_run++;
        if (trap_redirect !== 1'b0) begin
            fails++; $display("FAIL exc_redirect_pulse: got %b want 0", trap_redirect);
        end
        rd(12'h341);
        tests_run++;
        if (rd_s !== 32'h104) begin
            fails++; $display("FAIL exc_mepc: got %h want 104", rd_s);
        end
        rd(12'h342);
        tests_run++;
        if (rd_s !== 32'h2) begin
            fails++; $display("FAIL exc_mcause: got %h want 2", rd_s);
        end
        rd(12'h343);
        tests_run++;
        if (rd_s !== 32'h13) begin
            fails++; $display("FAIL exc_mtval: got %h want 13", rd_s);
        end
        rd(12'h300);
        tests_run++;
        if (rd_s !== 32'h1880) begin
            fails++; $display("FAIL exc_mstatus: got %h want 1880", rd_s);
        end
    endtask

    task automatic test_interrupt;
        csr_do(2'b01, 12'h304, 32'h888, 1'b1);
        csr_do(2'b01, 12'h305, 32'h201, 1'b1);
        csr_do(2'b01, 12'h300, 32'h8, 1'b1);
        meip = 1'b1; mtip = 1'b1;
        #1;
        tests_run++;
        if (irq_pending !== 1'b1) begin
            fails++; $display("FAIL irq_pending_set: got %b want 1", irq_pending);
        end
        pulse_take(32'h40);
        tests_run++;
        if (trap_redirect !== 1'b1 || trap_pc !== 32'h22C) begin
            fails++; $display("FAIL irq_vector_pc: got %b/%h want 1/22c", trap_redirect, trap_pc);
        end
        tests_run++;
        if (irq_pending !== 1'b0) begin
            fails++; $display("FAIL irq_masked_after_take: got %b want 0", irq_pending);
        end
        rd(12'h342);
        tests_run++;
        if (rd_s !== 32'h8000_000B) begin
            fails++; $display("FAIL irq_mcause: got %h want 8000000b", rd_s);
        end
        rd(12'h341);
        tests_run++;
        if (rd_s !== 32'h40) begin
            fails++; $display("FAIL irq_mepc: got %h want 40", rd_s);
        end
        rd(12'h343);
        tests_run++;
        if (rd_s !== 32'h0) begin
            fails++; $display("FAIL irq_mtval: got %h want 0", rd_s);
        end
        pulse_mret();
        tests_run++;
        if (trap_redirect !== 1'b1 || trap_pc !== 32'h40) begin
            fails++; $display("FAIL mret_redirect: got %b/%h want 1/40", trap_redirect, trap_pc);
        end
        rd(12'h300);
        tests_run++;
        if (rd_s !== 32'h1888) begin
            fails++; $display("FAIL mret_mstatus: got %h want 1888", rd_s);
        end
        meip = 1'b0;
        lirq = 4'b0110;
        csr_do(2'b01, 12'h304, 32'h0006_0080, 1'b1);
        pulse_take(32'h80);
        tests_run++;
        if (trap_pc !== 32'h21C) begin
            fails++; $display("FAIL irq_mtip_over_local: got %h want 21c", trap_pc);
        end
        pulse_mret();
        mtip = 1'b0;
        pulse_take(32'h84);
        tests_run++;
        if (trap_pc !== 32'h244) begin
            fails++; $display("FAIL irq_lowest_local: got %h want 244", trap_pc);
        end
        rd(12'h342);
        tests_run++;
        if (rd_s !== 32'h8000_0011) begin
            fails++; $display("FAIL irq_local_mcause: got %h want 80000011", rd_s);
        end
        lirq = 4'b0000;
    endtask

    task automatic test_illegal;
        csr_do(2'b01, 12'hC00, 32'h55, 1'b1);
        tests_run++;
        if (ack_s !== 1'b1 || ill_s !== 1'b1 || rd_s !== 32'h0) begin
            fails++; $display("FAIL ill_cycle_write: got ack=%b ill=%b rd=%h want 1/1/0", ack_s, ill_s, rd_s);
        end
        csr_do(2'b01, 12'hC02, 32'h55, 1'b1);
        rd(12'hB02);
        tests_run++;
        if (rd_s !== 32'h0) begin
            fails++; $display("FAIL ill_no_change: got %h want 0", rd_s);
        end
        rd(12'h7C0);
        tests_run++;
        if (ack_s !== 1'b1 || ill_s !== 1'b1 || rd_s !== 32'h0) begin
            fails++; $display("FAIL ill_unimpl: got ack=%b ill=%b rd=%h want 1/1/0", ack_s, ill_s, rd_s);
        end
        csr_do(2'b10, 12'hF14, 32'h0, 1'b1);
        tests_run++;
        if (ill_s !== 1'b1) begin
            fails++; $display("FAIL ill_ro_rs_wr: got %b want 1", ill_s);
        end
        rd(12'hF14);
        tests_run++;
        if (ill_s !== 1'b0 || rd_s !== 32'h5) begin
            fails++; $display("FAIL ro_read_ok: got ill=%b rd=%h want 0/5", ill_s, rd_s);
        end
    endtask

    task automatic test_fields;
        csr_do(2'b01, 12'h341, 32'h123, 1'b1);
        rd(12'h341);
        tests_run++;
        if (rd_s !== 32'h120) begin
            fails++; $display("FAIL mepc_align: got %h want 120", rd_s);
        end
        csr_do(2'b01, 12'h305, 32'hFFFF_FFFF, 1'b1);
        rd(12'h305);
        tests_run++;
        if (rd_s !== 32'hFFFF_FFFD || rd1_s !== 32'hFFFF_FFFC) begin
            fails++; $display("FAIL mtvec_mode: got %h/%h want fffffffd/fffffffc", rd_s, rd1_s);
        end
        csr_do(2'b01, 12'h304, 32'hFFFF_FFFF, 1'b1);
        rd(12'h304);
        tests_run++;
        if (rd_s !== 32'h000F_0888 || rd1_s !== 32'h0003_0888) begin
            fails++; $display("FAIL mie_mask: got %h/%h want 000f0888/00030888", rd_s, rd1_s);
        end
    endtask

    task automatic test_priority;
        csr_req = 1'b1; csr_op = 2'b01; csr_addr = 12'h340;
        csr_wdata = 32'h1234; csr_wr_en = 1'b1;
        pulse_exc(5'd5, 32'h300, 32'h0);
        csr_req = 1'b0; csr_wr_en = 1'b0;
        tests_run++;
        if (csr_ack !== 1'b0 || trap_redirect !== 1'b1 || trap_pc !== 32'hFFFF_FFFC) begin
            fails++; $display("FAIL exc_beats_csr: got ack=%b redir=%b pc=%h want 0/1/fffffffc", csr_ack, trap_redirect, trap_pc);
        end
        rd(12'h340);
        tests_run++;
        if (rd_s !== 32'h33) begin
            fails++; $display("FAIL dropped_csr_write: got %h want 33", rd_s);
        end
        rd(12'h342);
        tests_run++;
        if (rd_s !== 32'h5) begin
            fails++; $display("FAIL prio_mcause: got %h want 5", rd_s);
        end
    endtask

    task automatic test_reset_mid;
        rst_n = 1'b0;
        csr_req = 1'b1; csr_op = 2'b01; csr_addr = 12'h340;
        csr_wdata = 32'h99; csr_wr_en = 1'b1;
        pulse_exc(5'd4, 32'h500, 32'h0);
        csr_req = 1'b0; csr_wr_en = 1'b0;
        tests_run++;
        if (trap_redirect !== 1'b0 || csr_ack !== 1'b0 || trap_pc !== 32'h0) begin
            fails++; $display("FAIL reset_cancels: got redir=%b ack=%b pc=%h want 0/0/0", trap_redirect, csr_ack, trap_pc);
        end
        rst_n = 1'b1;
        rd(12'h340);
        tests_run++;
        if (rd_s !== 32'h0) begin
            fails++; $display("FAIL reset_mscratch: got %h want 0", rd_s);
        end
        rd(12'h305);
        tests_run++;
        if (rd_s !== 32'h100) begin
            fails++; $display("FAIL reset_mtvec_again: got %h want 100", rd_s);
        end
        rd(12'h342);
        tests_run++;
        if (rd_s !== 32'h0) begin
            fails++; $display("FAIL reset_mcause: got %h want 0", rd_s);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        csr_req = 1'b0; csr_op = 2'b00; csr_addr = 12'h0;
        csr_wdata = 32'h0; csr_wr_en = 1'b0;
        retire = 1'b0; timer_tick = 1'b0;
        exc_valid = 1'b0; exc_cause = 5'd0;
        exc_pc = 32'h0; exc_tval = 32'h0;
        mret = 1'b0; msip = 1'b0; mtip = 1'b0; meip = 1'b0;
        lirq = 4'b0; irq_take = 1'b0; irq_pc = 32'h0;
        test_reset();
        test_rw_rs();
        test_back_to_back();
        test_counters();
        test_exception();
        test_interrupt();
        test_illegal();
        test_fields();
        test_priority();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
